// File: rtl/conc_stim_pkg.sv
// conc_stim_pkg: shared state encoding and opcode field layout for the stimulus player.
package conc_stim_pkg;
    localparam int OPW      = 8;
    localparam int OBS_BIT  = 7;
    localparam int STBI_BIT = 6;
    localparam int XIN_MSB  = 5;
    localparam int XIN_LSB  = 0;
    typedef enum logic [1:0] {IDLE, PRIME, PLAY, DONE} state_t;
endpackage

// File: rtl/conc_opcode_ram.sv
// conc_opcode_ram: DEPTH x OPW synchronous RAM; read enable low freezes the output word.
module conc_opcode_ram
    import conc_stim_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic           clock,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  logic [OPW-1:0] wdata,
    input  logic           re,
    input  logic [AW-1:0]  raddr,
    output logic [OPW-1:0] rdata
);
    logic [OPW-1:0] mem [DEPTH];
    always_ff @(posedge clock) begin
        if (we && ({1'b0, waddr} < (AW+1)'(DEPTH))) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/conc_stim_player.sv
// conc_stim_player: replays a loaded opcode image onto x_in/stbi/obs, one opcode per clock.
module conc_stim_player
    import conc_stim_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int CNTW  = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [AW-1:0]   ld_addr,
    input  logic [OPW-1:0]  ld_data,
    input  logic [AW:0]     len,
    input  logic            start,
    input  logic            hold,
    output logic [5:0]      x_in,
    output logic            stbi,
    output logic            obs,
    output logic [AW-1:0]   pc,
    output logic            busy,
    output logic            done,
    output logic [CNTW-1:0] step_cnt
);
    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d, raddr;
    logic [AW:0]     len_q, len_d, eff_len;
    logic [CNTW-1:0] step_q, step_d, step_inc;
    logic [OPW-1:0]  word;
    logic            re, we, more, play;

    assign eff_len  = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
    assign step_inc = &step_q ? step_q : step_q + 1'b1;
    assign more     = ({1'b0, pc_q} + 1'b1) < len_q;
    assign ld_ready = state_q == IDLE;
    assign we       = ld_valid && ld_ready;
    // The first fetch happens in PRIME so a write accepted alongside start is seen.
    assign raddr    = state_q == PRIME ? '0 : pc_q + 1'b1;
    assign play     = state_q == PLAY;
    assign x_in     = play ? word[XIN_MSB:XIN_LSB] : '0;
    assign stbi     = play && word[STBI_BIT];
    assign obs      = play && word[OBS_BIT];
    assign busy     = state_q == PRIME || play;
    assign done     = state_q == DONE;
    assign pc       = pc_q;
    assign step_cnt = step_q;

    conc_opcode_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clock(clock),
        .we(we),
        .waddr(ld_addr),
        .wdata(ld_data),
        .re(re),
        .raddr(raddr),
        .rdata(word)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        step_d  = step_q;
        re      = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                pc_d    = '0;
                step_d  = '0;
                len_d   = eff_len;
                state_d = eff_len == '0 ? DONE : PRIME;
            end
            PRIME: begin
                re      = 1'b1;
                step_d  = step_inc;
                state_d = PLAY;
            end
            PLAY: if (!hold) begin
                re      = more;
                pc_d    = more ? pc_q + 1'b1 : pc_q;
                step_d  = more ? step_inc : step_q;
                state_d = more ? PLAY : DONE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
